// File: rtl/tmds_pkg.sv
// Shared types and symbol constants for the TMDS lane array.
// The TERC4 table is only referenced when TERC4_EN is defined.
package tmds_pkg;

  typedef enum logic [1:0] {
    ModeCtl    = 2'b00,
    ModeVideo  = 2'b01,
    ModeGuard  = 2'b10,
    ModeIsland = 2'b11
  } tmds_mode_e;

  // Control tokens indexed by the 2-bit control value.
  localparam logic [3:0][9:0] CtlToken = {
    10'b1010101011,  // 11
    10'b0101010100,  // 10
    10'b0010101011,  // 01
    10'b1101010100   // 00
  };

  // Guard-band symbols: lanes with index mod 3 in {0,2}, and index mod 3 == 1.
  localparam logic [9:0] GuardSym02 = 10'b1011001100;
  localparam logic [9:0] GuardSym1  = 10'b0100110011;

  // HDMI TERC4 codes indexed by the data-island nibble.
  localparam logic [15:0][9:0] Terc4Table = {
    10'b1011000011,  // 15
    10'b0101100011,  // 14
    10'b1001110001,  // 13
    10'b1010001110,  // 12
    10'b1011000110,  // 11
    10'b0110011100,  // 10
    10'b0100111001,  // 9
    10'b1011001100,  // 8
    10'b0100111100,  // 7
    10'b0110001110,  // 6
    10'b0100011110,  // 5
    10'b0101110001,  // 4
    10'b1011100010,  // 3
    10'b1011100100,  // 2
    10'b1001100011,  // 1
    10'b1010011100   // 0
  };

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: capture, transition-minimising stage, DC-balancing stage
// and serializer. All pipeline stages advance only on the symbol strobe.
// TERC4_EN: when defined, data-island mode emits TERC4 codes.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int unsigned SER_W    = 10,
  parameter int unsigned LANE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  tmds_mode_e       mode,
  input  logic [7:0]       data,
  input  logic [1:0]       ctl,
  input  logic [3:0]       terc,
  output logic [SER_W-1:0] tmds
);

  tmds_mode_e        cap_mode_q;
  logic [7:0]        cap_data_q;
  logic [1:0]        cap_ctl_q;
  logic [3:0]        cap_terc_q;

  logic              s1_video_q;
  logic [8:0]        s1_qm_q;
  logic [9:0]        s1_sym_q;

  logic [9:0]        s2_sym_q;
  logic signed [5:0] cnt_q;

  logic [9:0]        ser_q;

  logic [3:0]        n1_d;
  logic              use_xnor;
  logic [8:0]        qm_d;
  logic [9:0]        fix_sym_d;

  logic [3:0]        n1_m;
  logic signed [5:0] diff;
  logic [9:0]        s2_sym_d;
  logic signed [5:0] cnt_d;

  // Capture stage; the top already substitutes the injected control symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_mode_q <= ModeCtl;
      cap_data_q <= '0;
      cap_ctl_q  <= 2'b00;
    end else if (strobe) begin
      cap_mode_q <= mode;
      cap_data_q <= data;
      cap_ctl_q  <= ctl;
    end
  end

`ifdef TERC4_EN
  // Data-island nibble capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_terc_q <= '0;
    end else if (strobe) begin
      cap_terc_q <= terc;
    end
  end
`else
  assign cap_terc_q = '0;
  logic unused_terc;
  assign unused_terc = ^{terc, cap_terc_q};
`endif

  // Transition-minimisation: XNOR chain for dense bytes, XOR otherwise.
  always_comb begin
    qm_d     = '0;
    n1_d     = count_ones(cap_data_q);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !cap_data_q[0]);
    qm_d[0]  = cap_data_q[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ cap_data_q[i]) : (qm_d[i-1] ^ cap_data_q[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  // Fixed symbol for every non-video mode, resolved one stage early.
  always_comb begin
    fix_sym_d = CtlToken[cap_ctl_q];
    case (cap_mode_q)
      ModeGuard:  fix_sym_d = ((LANE_IDX % 3) == 1) ? GuardSym1 : GuardSym02;
`ifdef TERC4_EN
      ModeIsland: fix_sym_d = Terc4Table[cap_terc_q];
`endif
      default:    ;
    endcase
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_video_q <= 1'b0;
      s1_qm_q    <= '0;
      s1_sym_q   <= CtlToken[0];
    end else if (strobe) begin
      s1_video_q <= (cap_mode_q == ModeVideo);
      s1_qm_q    <= qm_d;
      s1_sym_q   <= fix_sym_d;
    end
  end

  // DC balancing; diff is N1-N0 of q_m[7:0]. Non-video symbols zero the disparity.
  always_comb begin
    n1_m     = count_ones(s1_qm_q[7:0]);
    diff     = $signed({1'b0, n1_m, 1'b0}) - 6'sd8;
    s2_sym_d = s1_sym_q;
    cnt_d    = '0;
    if (s1_video_q) begin
      if ((cnt_q == '0) || (diff == '0)) begin
        s2_sym_d = {~s1_qm_q[8], s1_qm_q[8], s1_qm_q[8] ? s1_qm_q[7:0] : ~s1_qm_q[7:0]};
        cnt_d    = s1_qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if ((!cnt_q[5] && !diff[5]) || (cnt_q[5] && diff[5])) begin
        s2_sym_d = {1'b1, s1_qm_q[8], ~s1_qm_q[7:0]};
        cnt_d    = cnt_q + (s1_qm_q[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        s2_sym_d = {1'b0, s1_qm_q[8], s1_qm_q[7:0]};
        cnt_d    = cnt_q - (s1_qm_q[8] ? 6'sd0 : 6'sd2) + diff;
      end
    end
  end

  // Stage 2 register with running disparity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sym_q <= CtlToken[0];
      cnt_q    <= '0;
    end else if (strobe) begin
      s2_sym_q <= s2_sym_d;
      cnt_q    <= cnt_d;
    end
  end

  // Serializer: load on strobe, otherwise shift LSB-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_q <= '0;
    end else if (strobe) begin
      ser_q <= s2_sym_q;
    end else begin
      ser_q <= ser_q >> SER_W;
    end
  end

  assign tmds = ser_q[SER_W-1:0];

endmodule

// File: rtl/tmds_lane_array.sv
// Array of TMDS lanes sharing a symbol-phase counter, handshake and
// underflow tracking. TERC4_EN: when defined, data-island mode emits TERC4.
module tmds_lane_array
  import tmds_pkg::*;
#(
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned SER_W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_mode,
  input  logic [NUM_LANES*8-1:0]     in_data,
  input  logic [NUM_LANES*2-1:0]     in_ctl,
  input  logic [NUM_LANES*4-1:0]     in_terc,
  input  logic                       clr_underflow,
  output logic [NUM_LANES*SER_W-1:0] tmds_out,
  output logic                       sym_strobe,
  output logic                       underflow
);

  localparam int unsigned PhaseMax = 10 / SER_W - 1;

  logic [3:0] phase_q;
  logic       armed_q;
  logic       underflow_q;
  logic       uf_set;
  tmds_mode_e eff_mode;

  // Symbol-phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= (phase_q == PhaseMax[3:0]) ? '0 : phase_q + 4'd1;
    end
  end

  assign sym_strobe = (phase_q == '0);
  assign in_ready   = sym_strobe;

  // A missing symbol only counts as underflow once the source has started.
  assign uf_set = sym_strobe && !in_valid && armed_q;

  // Armed flag and sticky underflow; a new underflow beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (sym_strobe && in_valid) begin
        armed_q <= 1'b1;
      end
      if (uf_set) begin
        underflow_q <= 1'b1;
      end else if (clr_underflow) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign underflow = underflow_q;
  assign eff_mode  = in_valid ? tmds_mode_e'(in_mode) : ModeCtl;

  for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
    tmds_lane #(
      .SER_W    (SER_W),
      .LANE_IDX (i)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .strobe (sym_strobe),
      .mode   (eff_mode),
      .data   (in_data[8*i +: 8]),
      .ctl    (in_valid ? in_ctl[2*i +: 2] : 2'b00),
      .terc   (in_terc[4*i +: 4]),
      .tmds   (tmds_out[i*SER_W +: SER_W])
    );
  end

endmodule

// File: tb/tb_tmds_lane_array.sv
// Directed bench for tmds_lane_array: three instances covering SER_W=10, 1, 2.
module tb_tmds_lane_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance A: 3 lanes, SER_W=10
  logic        rst_a = 1'b1, a_valid = 1'b0, a_ready, a_clr = 1'b0, a_strobe, a_uf;
  logic [1:0]  a_mode = 2'b00;
  logic [23:0] a_data = '0;
  logic [5:0]  a_ctl = '0;
  logic [11:0] a_terc = '0;
  logic [29:0] a_out;

  tmds_lane_array #(.NUM_LANES(3), .SER_W(10)) u_dut_a (
    .clk(clk), .rst(rst_a), .in_valid(a_valid), .in_ready(a_ready), .in_mode(a_mode),
    .in_data(a_data), .in_ctl(a_ctl), .in_terc(a_terc), .clr_underflow(a_clr),
    .tmds_out(a_out), .sym_strobe(a_strobe), .underflow(a_uf)
  );

  // Instance B: 3 lanes, SER_W=1
  logic        rst_b = 1'b1, b_valid = 1'b0, b_ready, b_strobe, b_uf;
  logic [1:0]  b_mode = 2'b10;
  logic [23:0] b_data = '0;
  logic [5:0]  b_ctl = '0;
  logic [11:0] b_terc = '0;
  logic [2:0]  b_out;

  tmds_lane_array #(.NUM_LANES(3), .SER_W(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_valid), .in_ready(b_ready), .in_mode(b_mode),
    .in_data(b_data), .in_ctl(b_ctl), .in_terc(b_terc), .clr_underflow(1'b0),
    .tmds_out(b_out), .sym_strobe(b_strobe), .underflow(b_uf)
  );

  // Instance C: 1 lane, SER_W=2
  logic       rst_c = 1'b1, c_valid = 1'b0, c_ready, c_strobe, c_uf;
  logic [1:0] c_mode = 2'b00;
  logic [7:0] c_data = '0;
  logic [1:0] c_ctl = '0;
  logic [3:0] c_terc = '0;
  logic [1:0] c_out;

  tmds_lane_array #(.NUM_LANES(1), .SER_W(2)) u_dut_c (
    .clk(clk), .rst(rst_c), .in_valid(c_valid), .in_ready(c_ready), .in_mode(c_mode),
    .in_data(c_data), .in_ctl(c_ctl), .in_terc(c_terc), .clr_underflow(1'b0),
    .tmds_out(c_out), .sym_strobe(c_strobe), .underflow(c_uf)
  );

  typedef struct {
    logic       valid;
    logic [1:0] mode;
    logic [7:0] data;
    logic [1:0] ctl;
    logic       clr;
    logic [9:0] exp0;
    logic [9:0] exp1;
    int         cnt;
    logic       uf;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] m, input logic [7:0] d,
                              input logic [1:0] c, input logic clr, input logic [9:0] e0,
                              input logic [9:0] e1, input int cnt, input logic uf);
    vec_t r;
    r.valid = v; r.mode = m; r.data = d; r.ctl = c; r.clr = clr;
    r.exp0 = e0; r.exp1 = e1; r.cnt = cnt; r.uf = uf;
    return r;
  endfunction

`ifdef TERC4_EN
  localparam logic [9:0] IslandExp = 10'b1010011100;
`else
  localparam logic [9:0] IslandExp = 10'b0010101011;
`endif

  vec_t              va [$];
  logic [9:0]        out0 [19];
  logic [9:0]        out1 [19];
  logic signed [5:0] cnt_h [19];
  logic [9:0]        g0, g1, g2;
  logic [1:0]        cp [21];
  logic [9:0]        w;

  initial begin
    // video: hand-derived DC-balance sequence
    va.push_back(mk(1, 2'b01, 8'h00, 2'b00, 0, 10'b0100000000, 10'b0100000000, -8, 0));
    va.push_back(mk(1, 2'b01, 8'h00, 2'b00, 0, 10'b1111111111, 10'b1111111111,  2, 0));
    va.push_back(mk(1, 2'b01, 8'hFF, 2'b00, 0, 10'b1000000000, 10'b1000000000, -6, 0));
    va.push_back(mk(1, 2'b01, 8'hFF, 2'b00, 0, 10'b0011111111, 10'b0011111111,  0, 0));
    va.push_back(mk(1, 2'b01, 8'h55, 2'b00, 0, 10'b0100110011, 10'b0100110011,  0, 0));
    va.push_back(mk(1, 2'b01, 8'h03, 2'b00, 0, 10'b0100000001, 10'b0100000001, -6, 0));
    va.push_back(mk(1, 2'b01, 8'h03, 2'b00, 0, 10'b1111111110, 10'b1111111110,  2, 0));
    // control tokens
    va.push_back(mk(1, 2'b00, 8'h00, 2'b00, 0, 10'b1101010100, 10'b1101010100,  0, 0));
    va.push_back(mk(1, 2'b00, 8'h00, 2'b01, 0, 10'b0010101011, 10'b0010101011,  0, 0));
    va.push_back(mk(1, 2'b00, 8'h00, 2'b10, 0, 10'b0101010100, 10'b0101010100,  0, 0));
    va.push_back(mk(1, 2'b00, 8'h00, 2'b11, 0, 10'b1010101011, 10'b1010101011,  0, 0));
    // data island nibble 0, ctl 01
    va.push_back(mk(1, 2'b11, 8'h00, 2'b01, 0, IslandExp, IslandExp, 0, 0));
    // guard band
    va.push_back(mk(1, 2'b10, 8'h00, 2'b00, 0, 10'b1011001100, 10'b0100110011, 0, 0));
    // underflow, clear, clear coincident with new underflow
    va.push_back(mk(0, 2'b01, 8'hAA, 2'b11, 0, 10'b1101010100, 10'b1101010100, 0, 1));
    va.push_back(mk(1, 2'b00, 8'h00, 2'b01, 1, 10'b0010101011, 10'b0010101011, 0, 0));
    va.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 10'b1101010100, 10'b1101010100, 0, 1));

    // ---------------- instance A ----------------
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_out", {2'b00, a_out}, 32'd0);
    rst_a = 1'b0;
    check("a_rst_strobe", a_strobe, 1);
    check("a_rst_ready", a_ready, 1);
    check("a_rst_uf", a_uf, 0);
    for (int c = 0; c < 19; c++) begin
      if (c < 16) begin
        a_valid = va[c].valid; a_mode = va[c].mode; a_data = {3{va[c].data}};
        a_ctl = {3{va[c].ctl}}; a_clr = va[c].clr;
      end else begin
        a_valid = 1'b0; a_clr = 1'b0;
      end
      @(posedge clk);
      #1;
      out0[c]  = a_out[9:0];
      out1[c]  = a_out[19:10];
      cnt_h[c] = u_dut_a.gen_lane[0].u_lane.cnt_q;
      if (c < 16) check($sformatf("a_uf[%0d]", c), a_uf, va[c].uf);
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("a_sym0[%0d]", k), out0[k+3], va[k].exp0);
      check($sformatf("a_sym1[%0d]", k), out1[k+3], va[k].exp1);
      check($sformatf("a_cnt[%0d]", k), {{26{cnt_h[k+2][5]}}, cnt_h[k+2]}, va[k].cnt);
    end

    // ---------------- instance B ----------------
    rst_b = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (t < 21) check($sformatf("b_strobe[%0d]", t), b_strobe, (t % 10) == 0);
      if (t == 9 || t == 35) check($sformatf("b_uf[%0d]", t), b_uf, 0);
      if (t >= 41 && t <= 50) begin
        g0[t-41] = b_out[0]; g1[t-41] = b_out[1]; g2[t-41] = b_out[2];
      end
      b_valid = (t >= 10);
      @(posedge clk);
      #1;
    end
    check("b_guard_l0", g0, 10'b1011001100);
    check("b_guard_l1", g1, 10'b0100110011);
    check("b_guard_l2", g2, 10'b1011001100);

    // ---------------- instance C ----------------
    rst_c = 1'b0;
    c_valid = 1'b1; c_mode = 2'b00; c_ctl = 2'b01;
    for (int t = 0; t < 18; t++) begin
      @(posedge clk);
      #1;
    end
    check("c_pre_rst", c_out, 2'b10);
    rst_c = 1'b1;
    #1;
    check("c_rst_now", c_out, 2'b00);
    @(posedge clk);
    #1;
    rst_c = 1'b0;
    c_ctl = 2'b10;
    check("c_rel_strobe", c_strobe, 1);
    check("c_rel_ready", c_ready, 1);
    check("c_rel_out", c_out, 2'b00);
    for (int t = 0; t < 21; t++) begin
      cp[t] = c_out;
      @(posedge clk);
      #1;
    end
    for (int j = 0; j < 5; j++) w[2*j +: 2] = cp[1+j];
    check("c_early", w, 10'b1101010100);
    for (int j = 0; j < 5; j++) w[2*j +: 2] = cp[11+j];
    check("c_late_reset_tok", w, 10'b1101010100);
    for (int j = 0; j < 5; j++) w[2*j +: 2] = cp[16+j];
    check("c_first_sym", w, 10'b0101010100);
    check("c_uf", c_uf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmds_lane_array.md
TMDS_LANE_ARRAY -- requirements
Module: tmds_lane_array

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3: number of independent TMDS lanes; legal values 1..8.
REQ-002 SHALL have parameter SER_W, default 10: serial bits emitted per lane per clock; legal values 1, 2, 5, 10.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: source presents a symbol set.
REQ-006 SHALL have port in_ready, output, 1: block accepts a symbol set this cycle.
REQ-007 SHALL have port in_mode, input, 2: mode, shared by all lanes; 00 control, 01 video, 10 guard band, 11 data island.
REQ-008 SHALL have port in_data, input, NUM_LANES*8: video byte per lane; lane i at [8i+7:8i].
REQ-009 SHALL have port in_ctl, input, NUM_LANES*2: control bits per lane.
REQ-010 SHALL have port in_terc, input, NUM_LANES*4: data-island nibble per lane.
REQ-011 SHALL have port clr_underflow, input, 1: clears underflow flag.
REQ-012 SHALL have port tmds_out, output, NUM_LANES*SER_W: serial bits; lane i at [i*SER_W +: SER_W]; bit 0 is transmitted first.
REQ-013 SHALL have port sym_strobe, output, 1: symbol-boundary pulse.
REQ-014 SHALL have port underflow, output, 1: sticky underflow flag.

Function
REQ-015 SHALL count a symbol-phase counter 0..(10/SER_W-1), wrapping; sym_strobe=1 when the counter is 0 (every cycle when SER_W=10).
REQ-016 SHALL drive in_ready = sym_strobe; a symbol set transfers when in_valid&&in_ready; in_valid without in_ready is ignored.
REQ-017 SHALL advance a 3-stage per-lane pipeline only on sym_strobe: capture, stage-1 (q_m), stage-2 (10-bit + disparity). First bits of a symbol accepted at strobe k appear on tmds_out in the cycle after strobe k+3.
REQ-018 Stage-1 SHALL use the DVI transition-minimisation rule: XNOR chain if N1(d)>4, or N1(d)==4 and d[0]==0; otherwise XOR chain; q_m[8]=1 for XOR.
REQ-019 Stage-2 SHALL apply DVI DC balancing with a signed 6-bit per-lane disparity cnt:
  - if cnt==0 or N1(q_m[7:0])==N0: q_out = {~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8] ? N1-N0 : N0-N1.
  - else if (cnt>0 && N1>N0) or (cnt<0 && N0>N1): invert; cnt += 2*q_m[8] + N0-N1.
  - else: no inversion; cnt += -2*~q_m[8] + N1-N0.
REQ-020 Control mode SHALL emit per in_ctl: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011 (written MSB..LSB); cnt is forced to 0.
REQ-021 Guard-band mode SHALL emit 1011001100 on lanes with i%3 in {0,2} and 0100110011 on i%3==1; cnt is forced to 0.
REQ-022 The serializer SHALL load the stage-2 symbol on sym_strobe and shift right by SER_W each cycle, presenting the low SER_W bits.
REQ-023 Underflow: a strobe with in_valid=0 after the first accepted transfer SHALL inject a control symbol (ctl=00) and set underflow; strobes before the first transfer inject the same symbol without flagging.
REQ-024 underflow SHALL be cleared by clr_underflow; a simultaneous set wins.

Reset
REQ-025 On rst SHALL force: counter 0, all cnt 0, pipeline stages to control ctl=00, serializer register 0, tmds_out 0, underflow 0, armed flag 0; sym_strobe=1 and in_ready=1 in the first cycle after release.
REQ-026 Reset mid-symbol SHALL abandon the partial symbol; no stale bits follow release.

Configuration
REQ-027 With TERC4_EN defined, mode 11 SHALL emit the HDMI TERC4 code for in_terc, and cnt is forced to 0.
REQ-028 Without TERC4_EN, mode 11 SHALL be encoded as control mode using in_ctl; the TERC4 table is not synthesised.

Structure
REQ-029 Package tmds_pkg SHALL hold: mode enum, four control tokens, two guard-band constants, and the 16-entry TERC4 table.
REQ-030 SHALL contain sub-module tmds_lane (pipeline, disparity, serializer), instantiated NUM_LANES times; counter, handshake and underflow logic are shared at top level.

Verification
REQ-031 SER_W=10, lane0 video 0x00 twice from reset → symbols 0100000000 then 1111111111; cnt -8 then +2.
REQ-032 Control ctl=00,01,10,11 → exactly the REQ-020 tokens; lane cnt reads 0 afterwards.
REQ-033 SER_W=1, NUM_LANES=3 guard band → lanes 0/2 serialize 0,0,1,1,0,0,1,1,0,1; lane1 serializes the complement; strobe every 10 cycles.
REQ-034 Accept one symbol, then hold in_valid=0 for one strobe → underflow=1, control 1101010100 emitted; pulse clr_underflow → 0; clear coincident with a new underflow → stays 1.
REQ-035 Assert rst in cycle 4 of a SER_W=2 symbol → tmds_out=0 immediately; after release sym_strobe=1; first accepted symbol emerges after strobe k+3.
REQ-036 With TERC4_EN, mode 11 nibble 0x0 → 1010011100; without it → control token per in_ctl.
